axis_pkt_gen: RTL and testbench

AXI4-Stream packet generator that feeds the S2MM (stream-to-memory) channel of the DMA in the MicroBlaze block design. It is the transmit end of the stream interface the DMA receives on. Software triggers a burst of fixed-length packets carrying an incrementing data pattern. The DMA writes these to memory for checking, and a 6-bit status output drives the board RGB LEDs.

---
 rtl/axis_pkt_gen.sv | 201 ++++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axis_pkt_gen
//
// AXI4-Stream packet generator that drives the S2MM channel of the DMA.
// A start pulse launches a burst of num_pkts packets, each pkt_len beats long,
// separated by gap idle cycles. The data pattern starts at seed and increments
// by one on every accepted beat, continuing across packet boundaries.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   start                one-cycle launch pulse (ignored while busy)
//   pkt_len, num_pkts,   burst configuration, sampled on start
//   gap, seed
//   m_axis_*             AXI4-Stream master (all outputs registered)
//   busy                 burst in progress
//   done                 one-cycle pulse at burst completion
//   pkt_cnt              packets fully accepted in the current/last burst
//   status_led           {busy, done_sticky, pkt_cnt[3:0]}
// -----------------------------------------------------------------------------
module axis_pkt_gen #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic [7:0]            num_pkts,
    input  logic [7:0]            gap,
    input  logic [DATA_W-1:0]     seed,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            pkt_cnt,
    output logic [5:0]            status_led
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t             state_reg,  state_next;
    logic [DATA_W-1:0]  tdata_reg,  tdata_next;
    logic               tvalid_reg, tvalid_next;
    logic               tlast_reg,  tlast_next;
    logic [LEN_W-1:0]   beat_reg,   beat_next;
    logic [7:0]         pkt_cnt_reg, pkt_cnt_next;
    logic [7:0]         gap_cnt_reg, gap_cnt_next;
    logic [LEN_W-1:0]   len_reg,    len_next;
    logic [7:0]         num_reg,    num_next;
    logic [7:0]         gap_reg,    gap_next;
    logic               done_reg,   done_next;
    logic               sticky_reg, sticky_next;

    logic               xfer;
    logic [LEN_W-1:0]   beat_inc;
    logic [7:0]         pkt_inc;

    // Byte enables are constant: every beat carries full-width data.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W/8; gi++) begin : g_keep
            assign m_axis_tkeep[gi] = 1'b1;
        end
    endgenerate

    assign xfer     = tvalid_reg & m_axis_tready;
    assign beat_inc = beat_reg + LEN_W'(1);
    assign pkt_inc  = pkt_cnt_reg + 8'd1;

    always_comb begin
        state_next   = state_reg;
        tdata_next   = tdata_reg;
        tvalid_next  = tvalid_reg;
        tlast_next   = tlast_reg;
        beat_next    = beat_reg;
        pkt_cnt_next = pkt_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        len_next     = len_reg;
        num_next     = num_reg;
        gap_next     = gap_reg;
        done_next    = 1'b0;
        sticky_next  = sticky_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    len_next     = pkt_len;
                    num_next     = num_pkts;
                    gap_next     = gap;
                    tdata_next   = seed;
                    beat_next    = '0;
                    pkt_cnt_next = 8'd0;
                    sticky_next  = 1'b0;
                    if (pkt_len == '0 || num_pkts == 8'd0) begin
                        // Empty burst: no beats, straight to completion.
                        state_next = S_FIN;
                    end else begin
                        // First beat is presented in the cycle right after start.
                        state_next  = S_SEND;
                        tvalid_next = 1'b1;
                        tlast_next  = (pkt_len == LEN_W'(1));
                    end
                end
            end

            S_SEND: begin
                if (xfer) begin
                    tdata_next = tdata_reg + DATA_W'(1);
                    if (tlast_reg) begin
                        pkt_cnt_next = pkt_inc;
                        beat_next    = '0;
                        if (pkt_inc == num_reg) begin
                            state_next  = S_FIN;
                            tvalid_next = 1'b0;
                            tlast_next  = 1'b0;
                        end else if (gap_reg == 8'd0) begin
                            // Back-to-back packet: keep tvalid high, no bubble.
                            tlast_next = (len_reg == LEN_W'(1));
                        end else begin
                            state_next   = S_GAP;
                            tvalid_next  = 1'b0;
                            tlast_next   = 1'b0;
                            gap_cnt_next = 8'd0;
                        end
                    end else begin
                        beat_next  = beat_inc;
                        tlast_next = (beat_inc == len_reg - LEN_W'(1));
                    end
                end
            end

            S_GAP: begin
                // The cycle that leaves GAP re-asserts tvalid, so the final
                // count value is gap-1 to produce exactly gap idle cycles.
                if (gap_cnt_reg == gap_reg - 8'd1) begin
                    state_next  = S_SEND;
                    tvalid_next = 1'b1;
                    tlast_next  = (len_reg == LEN_W'(1));
                end else begin
                    gap_cnt_next = gap_cnt_reg + 8'd1;
                end
            end

            S_FIN: begin
                done_next   = 1'b1;
                sticky_next = 1'b1;
                state_next  = S_IDLE;
            end

            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg   <= S_IDLE;
            tdata_reg   <= '0;
            tvalid_reg  <= 1'b0;
            tlast_reg   <= 1'b0;
            beat_reg    <= '0;
            pkt_cnt_reg <= 8'd0;
            gap_cnt_reg <= 8'd0;
            len_reg     <= '0;
            num_reg     <= 8'd0;
            gap_reg     <= 8'd0;
            done_reg    <= 1'b0;
            sticky_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tdata_reg   <= tdata_next;
            tvalid_reg  <= tvalid_next;
            tlast_reg   <= tlast_next;
            beat_reg    <= beat_next;
            pkt_cnt_reg <= pkt_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            len_reg     <= len_next;
            num_reg     <= num_next;
            gap_reg     <= gap_next;
            done_reg    <= done_next;
            sticky_reg  <= sticky_next;
        end
    end

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tlast  = tlast_reg;
    assign busy          = (state_reg != S_IDLE);
    assign done          = done_reg;
    assign pkt_cnt       = pkt_cnt_reg;
    assign status_led    = {busy, sticky_reg, pkt_cnt_reg[3:0]};

endmodule

// File: tb/tb_axis_pkt_gen.sv
`timescale 1ns/1ps
module tb_axis_pkt_gen;

    logic        clk;
    logic        aresetn;
    logic        start;
    logic [15:0] pkt_len;
    logic [7:0]  num_pkts;
    logic [7:0]  gap;
    logic [31:0] seed;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        busy;
    logic        done;
    logic [7:0]  pkt_cnt;
    logic [5:0]  status_led;

    int pass_cnt  = 0;
    int check_cnt = 0;

    axis_pkt_gen #(.DATA_W(32), .LEN_W(16)) dut (
        .aclk          (clk),
        .aresetn       (aresetn),
        .start         (start),
        .pkt_len       (pkt_len),
        .num_pkts      (num_pkts),
        .gap           (gap),
        .seed          (seed),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .busy          (busy),
        .done          (done),
        .pkt_cnt       (pkt_cnt),
        .status_led    (status_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] len;
        logic [7:0]  num;
        logic [7:0]  gap;
        logic [31:0] seed;
        int          rdy;          // 1: tready held high, 2: random tready
        int          restart_at;   // loop cycle of a stray start pulse, -1 none
        int          exp_beats;
        int          exp_lasts;
        logic [31:0] exp_last_data;
        logic [7:0]  exp_pkt;
        int          exp_idle;     // total tvalid=0 cycles between packets
        int          exp_vcyc;     // tvalid=1 cycles, -1 to skip
        int          exp_done_cyc; // loop cycle done is seen, -1 to skip
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input logic [15:0] len, input logic [7:0] num,
                                input logic [7:0] g, input logic [31:0] sd,
                                input int rdy, input int rs, input int eb,
                                input int el, input logic [31:0] eld,
                                input logic [7:0] ep, input int ei,
                                input int ev, input int ed);
        vec_t v;
        v.len = len; v.num = num; v.gap = g; v.seed = sd;
        v.rdy = rdy; v.restart_at = rs;
        v.exp_beats = eb; v.exp_lasts = el; v.exp_last_data = eld;
        v.exp_pkt = ep; v.exp_idle = ei; v.exp_vcyc = ev; v.exp_done_cyc = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nb = 0, nl = 0, idle_pend = 0, idle_tot = 0, vcyc = 0, done_cyc = -1;
        logic prev_stall = 1'b0;
        logic [31:0] pd = '0;
        logic pl = 1'b0;
        logic [31:0] last_d = '0;
        logic [31:0] expd;
        bit seen = 0;

        tready   = 1'b1;
        pkt_len  = v.len;
        num_pkts = v.num;
        gap      = v.gap;
        seed     = v.seed;
        start    = 1'b1;
        step;
        start    = 1'b0;

        chk("start_busy", busy, 1);
        if (v.exp_beats > 0) begin
            chk("start_valid", tvalid, 1);
            chk("start_data", tdata, v.seed);
        end else begin
            chk("start_novalid", tvalid, 0);
        end

        for (int cyc = 0; cyc < 600; cyc++) begin
            if (done) begin
                seen = 1;
                done_cyc = cyc;
                break;
            end
            start = (cyc == v.restart_at);
            if (start) begin
                pkt_len = 16'd1; num_pkts = 8'd9; gap = 8'd0; seed = 32'hDEAD0000;
            end
            tready = (v.rdy == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (prev_stall) begin
                chk("hold_valid", tvalid, 1);
                chk("hold_data", tdata, pd);
                chk("hold_last", tlast, pl);
            end
            if (tvalid) vcyc++;
            if (!tvalid && busy && nb > 0) idle_pend++;
            if (tvalid && tready) begin
                expd = v.seed + 32'(nb);
                chk("beat_data", tdata, expd);
                chk("beat_last", tlast, ((nb % int'(v.len)) == int'(v.len) - 1));
                if (tlast) nl++;
                idle_tot += idle_pend;
                idle_pend = 0;
                last_d = tdata;
                nb++;
            end
            prev_stall = tvalid && !tready;
            pd = tdata;
            pl = tlast;
            step;
        end
        start  = 1'b0;
        tready = 1'b1;

        chk("done_seen", seen, 1);
        chk("beats", nb, v.exp_beats);
        chk("tlasts", nl, v.exp_lasts);
        chk("idle_cycles", idle_tot, v.exp_idle);
        chk("pkt_cnt", pkt_cnt, v.exp_pkt);
        chk("busy_end", busy, 0);
        if (v.exp_beats > 0) chk("last_data", last_d, v.exp_last_data);
        if (v.exp_vcyc >= 0) chk("valid_cycles", vcyc, v.exp_vcyc);
        if (v.exp_done_cyc >= 0) chk("done_cycle", done_cyc, v.exp_done_cyc);
        step;
        chk("done_pulse_end", done, 0);
        $display("vec %0d: len=%0d num=%0d gap=%0d seed=0x%08h beats=%0d lasts=%0d pkt_cnt=%0d",
                 idx, v.len, v.num, v.gap, v.seed, nb, nl, pkt_cnt);
    endtask

    initial begin
        vec_t v;
        bit seen;

        vecs[0] = mk(16'd4, 8'd1, 8'd0, 32'h10,       1, -1,  4, 1, 32'h13,  8'd1, 0,  4,  5);
        vecs[1] = mk(16'd3, 8'd3, 8'd2, 32'hFFFFFFFE, 1, -1,  9, 3, 32'h6,   8'd3, 4,  9, 14);
        vecs[2] = mk(16'd8, 8'd2, 8'd0, 32'h100,      2, -1, 16, 2, 32'h10F, 8'd2, 0, -1, -1);
        vecs[3] = mk(16'd0, 8'd5, 8'd0, 32'h55,       1, -1,  0, 0, 32'h0,   8'd0, 0,  0,  1);
        vecs[4] = mk(16'd1, 8'd4, 8'd1, 32'hA0,       1, -1,  4, 4, 32'hA3,  8'd4, 3,  4, -1);
        vecs[5] = mk(16'd5, 8'd0, 8'd0, 32'h77,       1, -1,  0, 0, 32'h0,   8'd0, 0,  0,  1);
        vecs[6] = mk(16'd4, 8'd2, 8'd1, 32'h200,      1,  3,  8, 2, 32'h207, 8'd2, 1,  8, -1);

        aresetn  = 1'b0;
        start    = 1'b0;
        pkt_len  = '0;
        num_pkts = '0;
        gap      = '0;
        seed     = '0;
        tready   = 1'b1;
        repeat (3) step;

        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tkeep", tkeep, 4'hF);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_led", status_led, 0);
        aresetn = 1'b1;
        step;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset mid-packet, at beat 2 of 6.
        pkt_len = 16'd6; num_pkts = 8'd2; gap = 8'd0; seed = 32'h300; tready = 1'b1;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        step;
        chk("midpkt_beat2", tdata, 32'h302);
        #2 aresetn = 1'b0;
        #1;
        chk("async_tvalid", tvalid, 0);
        chk("async_busy", busy, 0);
        chk("async_pkt_cnt", pkt_cnt, 0);
        chk("async_tdata", tdata, 0);
        $display("async reset mid-packet: tvalid=%0d busy=%0d pkt_cnt=%0d", tvalid, busy, pkt_cnt);
        @(posedge clk);
        #1 aresetn = 1'b1;
        step;
        v = mk(16'd2, 8'd1, 8'd0, 32'h400, 1, -1, 2, 1, 32'h401, 8'd1, 0, 2, 3);
        run_vec(7, v);

        // status_led after a two-packet burst, then cleared sticky on restart.
        v = mk(16'd2, 8'd2, 8'd0, 32'h500, 1, -1, 4, 2, 32'h503, 8'd2, 0, 4, -1);
        run_vec(8, v);
        chk("led_after_burst", status_led, 6'b010010);
        $display("status_led after 2-packet burst = %06b", status_led);
        pkt_len = 16'd1; num_pkts = 8'd1; gap = 8'd0; seed = 32'h600;
        start = 1'b1;
        step;
        start = 1'b0;
        chk("led_on_start", status_led, 6'b100000);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) begin
                seen = 1;
                break;
            end
            step;
        end
        chk("led_done_seen", seen, 1);
        chk("led_final", status_led, 6'b010001);
        $display("status_led after 1-packet burst = %06b", status_led);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
